// File: rtl/gray_position_decoder.sv
// Receive side of a Gray-coded position link: synchronise, deglitch, convert to binary,
// emit single-step pulses with direction, count revolutions and flag illegal multi-bit jumps.
module gray_position_decoder #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int TURN_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  gray_in,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  pos_bin,
  output logic              pos_valid,
  output logic              step,
  output logic              dir,
  output logic [TURN_W-1:0] turns,
  output logic              err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int HD_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [WIDTH-1:0] POS_MAX = {WIDTH{1'b1}};

  typedef enum logic {ST_ACQ = 1'b0, ST_TRACK = 1'b1} state_t;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [HD_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [HD_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + HD_W'(v[i]);
    end
    return c;
  endfunction

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]  s_gray;
  logic [WIDTH-1:0]  cand_r, cand_nxt;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt;
  state_t            state_r, state_nxt;
  logic [WIDTH-1:0]  pos_nxt, new_bin;
  logic              valid_nxt, step_nxt, dir_nxt, err_nxt, accept;
  logic [TURN_W-1:0] turns_nxt;
  logic [HD_W-1:0]   hd;

  assign s_gray = sync_r[SYNC_STAGES-1];

  // Input synchroniser chain, free-running regardless of en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], gray_in};
    end
  end

  // Filter, acquisition/tracking FSM and output next-state logic
  always_comb begin
    cand_nxt  = cand_r;
    cnt_nxt   = cnt_r;
    state_nxt = state_r;
    pos_nxt   = pos_bin;
    valid_nxt = pos_valid;
    step_nxt  = 1'b0;
    dir_nxt   = dir;
    turns_nxt = turns;
    err_nxt   = err & ~(err_clr & en);
    accept    = 1'b0;

    if (!en) begin
      cnt_nxt = '0;
    end else if (s_gray != cand_r) begin
      cand_nxt = s_gray;
      cnt_nxt  = CNT_W'(1);
      accept   = (cnt_nxt == CNT_MAX);
    end else if (cnt_r < CNT_MAX) begin
      cnt_nxt = cnt_r + CNT_W'(1);
      accept  = (cnt_nxt == CNT_MAX);
    end else begin
      cnt_nxt = cnt_r;
    end

    new_bin = gray2bin(cand_nxt);
    hd      = popcount(cand_nxt ^ bin2gray(pos_bin));

    case (state_r)
      ST_ACQ: begin
        if (accept) begin
          pos_nxt   = new_bin;
          valid_nxt = 1'b1;
          state_nxt = ST_TRACK;
        end else begin
          state_nxt = ST_ACQ;
        end
      end
      ST_TRACK: begin
        // hd==0 is reachable when a glitch or en-drop makes the held code requalify; ignore it
        if (accept && hd == HD_W'(1)) begin
          pos_nxt  = new_bin;
          step_nxt = 1'b1;
          dir_nxt  = (new_bin == pos_bin + WIDTH'(1));
          if (pos_bin == POS_MAX && new_bin == '0) begin
            turns_nxt = turns + TURN_W'(1);
          end else if (pos_bin == '0 && new_bin == POS_MAX) begin
            turns_nxt = turns - TURN_W'(1);
          end else begin
            turns_nxt = turns;
          end
        end else if (accept && hd > HD_W'(1)) begin
          err_nxt   = 1'b1;
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ST_ACQ;
        end else begin
          state_nxt = ST_TRACK;
        end
      end
      default: begin
        state_nxt = ST_ACQ;
      end
    endcase
  end

  // State, filter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_ACQ;
      cand_r    <= '0;
      cnt_r     <= '0;
      pos_bin   <= '0;
      pos_valid <= 1'b0;
      step      <= 1'b0;
      dir       <= 1'b0;
      turns     <= '0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cand_r    <= cand_nxt;
      cnt_r     <= cnt_nxt;
      pos_bin   <= pos_nxt;
      pos_valid <= valid_nxt;
      step      <= step_nxt;
      dir       <= dir_nxt;
      turns     <= turns_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_gray_position_decoder.sv
// Directed, table-driven bench for gray_position_decoder (WIDTH=4, 2 sync stages, 3 stable cycles).
module tb_gray_position_decoder;

  logic       clk = 1'b0;
  logic       rst_n, en, err_clr;
  logic [3:0] gray_in;
  logic [3:0] pos_bin;
  logic       pos_valid, step, dir, err;
  logic [7:0] turns;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int s0;

  typedef struct {
    logic [3:0] gray;
    logic [3:0] bin;
    logic       dir;
    logic [7:0] turns;
  } vec_t;

  vec_t tab [32];

  gray_position_decoder #(
    .WIDTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(3), .TURN_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .gray_in(gray_in), .err_clr(err_clr),
    .pos_bin(pos_bin), .pos_valid(pos_valid), .step(step), .dir(dir),
    .turns(turns), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step === 1'b1) step_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    tab[0]  = '{4'b0001, 4'd1,  1'b1, 8'd0};
    tab[1]  = '{4'b0011, 4'd2,  1'b1, 8'd0};
    tab[2]  = '{4'b0010, 4'd3,  1'b1, 8'd0};
    tab[3]  = '{4'b0110, 4'd4,  1'b1, 8'd0};
    tab[4]  = '{4'b0111, 4'd5,  1'b1, 8'd0};
    tab[5]  = '{4'b0101, 4'd6,  1'b1, 8'd0};
    tab[6]  = '{4'b0100, 4'd7,  1'b1, 8'd0};
    tab[7]  = '{4'b1100, 4'd8,  1'b1, 8'd0};
    tab[8]  = '{4'b1101, 4'd9,  1'b1, 8'd0};
    tab[9]  = '{4'b1111, 4'd10, 1'b1, 8'd0};
    tab[10] = '{4'b1110, 4'd11, 1'b1, 8'd0};
    tab[11] = '{4'b1010, 4'd12, 1'b1, 8'd0};
    tab[12] = '{4'b1011, 4'd13, 1'b1, 8'd0};
    tab[13] = '{4'b1001, 4'd14, 1'b1, 8'd0};
    tab[14] = '{4'b1000, 4'd15, 1'b1, 8'd0};
    tab[15] = '{4'b0000, 4'd0,  1'b1, 8'd1};
    tab[16] = '{4'b1000, 4'd15, 1'b0, 8'd0};
    tab[17] = '{4'b1001, 4'd14, 1'b0, 8'd0};
    tab[18] = '{4'b1011, 4'd13, 1'b0, 8'd0};
    tab[19] = '{4'b1010, 4'd12, 1'b0, 8'd0};
    tab[20] = '{4'b1110, 4'd11, 1'b0, 8'd0};
    tab[21] = '{4'b1111, 4'd10, 1'b0, 8'd0};
    tab[22] = '{4'b1101, 4'd9,  1'b0, 8'd0};
    tab[23] = '{4'b1100, 4'd8,  1'b0, 8'd0};
    tab[24] = '{4'b0100, 4'd7,  1'b0, 8'd0};
    tab[25] = '{4'b0101, 4'd6,  1'b0, 8'd0};
    tab[26] = '{4'b0111, 4'd5,  1'b0, 8'd0};
    tab[27] = '{4'b0110, 4'd4,  1'b0, 8'd0};
    tab[28] = '{4'b0010, 4'd3,  1'b0, 8'd0};
    tab[29] = '{4'b0011, 4'd2,  1'b0, 8'd0};
    tab[30] = '{4'b0001, 4'd1,  1'b0, 8'd0};
    tab[31] = '{4'b0000, 4'd0,  1'b0, 8'd0};

    // 1: reset values and first acquisition
    en = 1'b1; err_clr = 1'b0; gray_in = 4'b0110; rst_n = 1'b0;
    #1;
    chk("reset_outputs", {pos_bin, pos_valid, step, dir, turns, err}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    s0 = step_cnt;
    tick(10);
    chk("acq_valid", pos_valid, 1);
    chk("acq_pos", pos_bin, 4);
    chk("acq_no_step", step_cnt - s0, 0);
    chk("acq_err", err, 0);

    // 2: full walk up through wrap, then back down through wrap
    gray_in = 4'b0000;
    do_reset();
    tick(8);
    chk("walk_start", pos_bin, 0);
    for (int i = 0; i < 32; i++) begin
      gray_in = tab[i].gray;
      s0 = step_cnt;
      tick(8);
      chk($sformatf("walk%0d_pos", i), pos_bin, tab[i].bin);
      chk($sformatf("walk%0d_dir", i), dir, tab[i].dir);
      chk($sformatf("walk%0d_turns", i), turns, tab[i].turns);
      chk($sformatf("walk%0d_step", i), step_cnt - s0, 1);
    end
    chk("walk_err", err, 0);

    // 3: short glitch from position 5 is ignored
    gray_in = 4'b0111;
    do_reset();
    tick(8);
    chk("glitch_start", pos_bin, 5);
    s0 = step_cnt;
    gray_in = 4'b0101;
    tick(2);
    gray_in = 4'b0111;
    tick(12);
    chk("glitch_pos", pos_bin, 5);
    chk("glitch_step", step_cnt - s0, 0);
    chk("glitch_err", err, 0);
    chk("glitch_valid", pos_valid, 1);

    // 4: illegal jump 5 -> 8, re-acquire, clear, then set-wins-over-clear
    gray_in = 4'b1100;
    tick(4);
    chk("jump_latency_err", err, 0);
    tick(1);
    chk("jump_err", err, 1);
    chk("jump_valid", pos_valid, 0);
    chk("jump_pos_hold", pos_bin, 5);
    s0 = step_cnt;
    tick(5);
    chk("reacq_valid", pos_valid, 1);
    chk("reacq_pos", pos_bin, 8);
    chk("reacq_no_step", step_cnt - s0, 0);
    chk("err_sticky", err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_cleared", err, 0);
    gray_in = 4'b0000;
    tick(4);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("set_wins", err, 1);
    chk("set_wins_valid", pos_valid, 0);

    // 5: en=0 freezes, step happens after requalification
    gray_in = 4'b0010;
    do_reset();
    tick(8);
    chk("en_start", pos_bin, 3);
    en = 1'b0;
    gray_in = 4'b0110;
    s0 = step_cnt;
    tick(10);
    chk("en_hold_pos", pos_bin, 3);
    chk("en_hold_step", step_cnt - s0, 0);
    en = 1'b1;
    tick(2);
    chk("en_requal_early", pos_bin, 3);
    tick(1);
    chk("en_step_pulse", step, 1);
    chk("en_step_dir", dir, 1);
    chk("en_step_pos", pos_bin, 4);
    tick(3);
    chk("en_step_count", step_cnt - s0, 1);

    // 6: async reset mid-walk at position 9 with two turns
    gray_in = 4'b0000;
    do_reset();
    tick(8);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        gray_in = tab[i].gray;
        tick(8);
      end
    end
    for (int i = 0; i < 9; i++) begin
      gray_in = tab[i].gray;
      tick(8);
    end
    chk("mid_pos", pos_bin, 9);
    chk("mid_turns", turns, 2);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {pos_bin, pos_valid, step, dir, turns, err}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    s0 = step_cnt;
    tick(8);
    chk("post_rst_pos", pos_bin, 9);
    chk("post_rst_valid", pos_valid, 1);
    chk("post_rst_turns", turns, 0);
    chk("post_rst_step", step_cnt - s0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
